// File: rtl/or1k_wb_pkg.sv
// or1k_wb_pkg: Wishbone B3 cycle/burst type codes shared by the
// memory slaves, plus the burst address sequencer.
package or1k_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Word address of the next burst beat; wrapping bursts only
    // advance the low bits and keep the aligned block fixed.
    function automatic logic [31:0] wrap_next(
        input logic [31:0] adr,
        input logic [1:0]  bte
    );
        logic [31:0] nxt;
        unique case (bte)
            BTE_LINEAR: nxt = adr + 32'd1;
            BTE_WRAP4:  nxt = {adr[31:2], adr[1:0] + 2'd1};
            BTE_WRAP8:  nxt = {adr[31:3], adr[2:0] + 3'd1};
            BTE_WRAP16: nxt = {adr[31:4], adr[3:0] + 4'd1};
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/or1k_wb_ram_generic.sv
// or1k_wb_ram_generic: word-wide RAM with synchronous read and
// per-byte write enables; mem is the backdoor load target.
module or1k_wb_ram_generic #(
    parameter int unsigned MEM_SIZE = 32'h02000000,
    parameter int          RAW      = 23
) (
    input  logic           clk,
    input  logic [3:0]     we,
    input  logic [RAW-1:0] waddr,
    input  logic [31:0]    din,
    input  logic           re,
    input  logic [RAW-1:0] raddr,
    output logic [31:0]    dout
);

    reg [31:0] mem [0:MEM_SIZE/4-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= din[b*8 +: 8];
        end
        if (re) dout <= mem[raddr];
    end

endmodule

// File: rtl/or1k_wb_ram.sv
// or1k_wb_ram: Wishbone B3 RAM slave for or1k_pu with classic
// cycles and registered-feedback linear/wrapping bursts.
module or1k_wb_ram
    import or1k_wb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 32'h02000000,
    parameter int          AW       = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int            WORDS = MEM_SIZE / 4;
    localparam int            RAW   = $clog2(WORDS);
    localparam logic [AW-3:0] TOP_W = (AW-2)'(WORDS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SINGLE = 2'd1;
    localparam logic [1:0] BURST  = 2'd2;

    logic [1:0]     state;
    logic [AW-3:0]  adr_q;
    logic [AW-3:0]  in_adr;
    logic [AW-3:0]  next_adr;
    logic [RAW-1:0] rd_adr;
    logic           ack_q;
    logic           err_q;
    logic           req;
    logic           beat;
    logic           last;
    logic           in_ok;
    logic           next_ok;
    logic           rd_en;
    logic [3:0]     wr_en;
    logic [31:0]    rd_dat;
    logic           unused_adr;

    assign req      = wb_cyc_i & wb_stb_i;
    assign beat     = (ack_q | err_q) & req;
    assign last     = (wb_cti_i == CTI_EOB) | (wb_cti_i == CTI_CLASSIC);
    assign in_adr   = wb_adr_i[AW-1:2];
    assign next_adr = (AW-2)'(wrap_next(32'(adr_q), wb_bte_i));
    assign in_ok    = in_adr < TOP_W;
    assign next_ok  = next_adr < TOP_W;

    // Prefetch the next beat so data is fresh on every ack cycle.
    assign rd_en  = (state == IDLE) ? (req & in_ok)
                  : (state == BURST) & beat & !last & next_ok;
    assign rd_adr = (state == IDLE) ? in_adr[RAW-1:0]
                                    : next_adr[RAW-1:0];
    assign wr_en  = (ack_q & req & wb_we_i & !wb_rst_i) ? wb_sel_i
                                                        : 4'b0000;

    // A master wait state (stb low) holds off the pending ack.
    assign wb_ack_o   = ack_q & req;
    assign wb_err_o   = err_q & req;
    assign wb_dat_o   = ack_q ? rd_dat : 32'd0;
    assign wb_rty_o   = 1'b0;
    assign unused_adr = ^wb_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            adr_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        adr_q <= in_adr;
                        ack_q <= in_ok;
                        err_q <= !in_ok;
                        state <= (wb_cti_i == CTI_INC) ? BURST : SINGLE;
                    end
                end
                SINGLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                BURST: begin
                    if (!wb_cyc_i || (beat && last)) begin
                        ack_q <= 1'b0;
                        err_q <= 1'b0;
                        state <= IDLE;
                    end else if (beat) begin
                        adr_q <= next_adr;
                        ack_q <= next_ok;
                        err_q <= !next_ok;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    or1k_wb_ram_generic #(
        .MEM_SIZE (MEM_SIZE),
        .RAW      (RAW)
    ) ram0 (
        .clk   (wb_clk_i),
        .we    (wr_en),
        .waddr (adr_q[RAW-1:0]),
        .din   (wb_dat_i),
        .re    (rd_en),
        .raddr (rd_adr),
        .dout  (rd_dat)
    );

endmodule

// File: tb/tb_or1k_wb_ram.sv
// tb_or1k_wb_ram: scoreboard bench for or1k_wb_ram with a small
// word-array reference model and randomized Wishbone traffic.
module tb_or1k_wb_ram;
    import or1k_wb_pkg::*;

    localparam int unsigned MSZ   = 32'h1000;
    localparam int          WORDS = MSZ / 4;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    logic [31:0] model [0:WORDS-1];
    exp_t        sbq[$];
    int          checks = 0;
    int          passed = 0;

    or1k_wb_ram #(
        .MEM_SIZE (MSZ),
        .AW       (32)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr_i),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel_i),
        .wb_we_i  (we_i),
        .wb_cyc_i (cyc_i),
        .wb_stb_i (stb_i),
        .wb_cti_i (cti_i),
        .wb_bte_i (bte_i),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack_o),
        .wb_err_o (err_o),
        .wb_rty_o (rty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Word visited by beat k of a burst starting at word w0.
    function automatic logic [31:0] beat_word(input logic [31:0] w0,
                                              input int k,
                                              input logic [1:0] bte);
        int n;
        n = (bte == 2'b00) ? 0 : (2 << bte);
        if (n == 0) return w0 + k;
        return (w0 / n) * n + ((w0 % n) + k) % n;
    endfunction

    task automatic expect_beat(input logic [31:0] w, input logic we,
                               input logic [3:0] sel,
                               input logic [31:0] dat);
        exp_t e;
        e.err = (w >= WORDS);
        e.rd  = !we;
        e.dat = 32'd0;
        if (!e.err && !we) e.dat = model[w];
        if (!e.err && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[w][b*8 +: 8] = dat[b*8 +: 8];
        end
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ack_o || err_o)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", {30'd0, ack_o, err_o}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_kind", {30'd0, ack_o, err_o},
                    {30'd0, !e.err, e.err});
                if (e.rd || e.err) chk("rd_data", dat_o, e.dat);
            end
        end
    end

    task automatic wait_resp(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_o || err_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic classic(input logic [31:0] adr, input logic we,
                           input logic [3:0] sel, input logic [31:0] dat);
        bit ok;
        @(posedge clk);
        #1;
        expect_beat(adr >> 2, we, sel, dat);
        adr_i = adr; we_i = we; sel_i = sel; dat_i = dat;
        cti_i = CTI_CLASSIC; bte_i = BTE_LINEAR;
        cyc_i = 1'b1; stb_i = 1'b1;
        wait_resp("classic", ok);
        if (ok) begin
            @(negedge clk);
            chk("classic_ack_drop", {30'd0, ack_o, err_o}, 32'd0);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic burst(input logic [31:0] adr, input logic we,
                         input logic [1:0] bte, input int n,
                         input int gap_at, input int gap_len);
        bit          ok;
        logic [31:0] w;
        logic [3:0]  sel;
        logic [31:0] dat;
        @(posedge clk);
        #1;
        cyc_i = 1'b1; we_i = we; bte_i = bte;
        for (int k = 0; k < n; k++) begin
            w   = beat_word(adr >> 2, k, bte);
            sel = we ? 4'($urandom) : 4'hf;
            dat = $urandom;
            expect_beat(w, we, sel, dat);
            adr_i = w << 2; sel_i = sel; dat_i = dat;
            cti_i = (k == n - 1) ? CTI_EOB : CTI_INC;
            stb_i = 1'b1;
            wait_resp("burst", ok);
            if (!ok) break;
            if (k == n - 1) begin
                @(negedge clk);
                chk("burst_ack_drop", {30'd0, ack_o, err_o}, 32'd0);
            end else begin
                @(posedge clk);
                #1;
                if (k == gap_at && gap_len > 0) begin
                    stb_i = 1'b0;
                    repeat (gap_len) begin
                        @(negedge clk);
                        chk("gap_no_ack", {30'd0, ack_o, err_o}, 32'd0);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = CTI_CLASSIC;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] v;
        logic [31:0] d0;
        int          bad;
        int          first;

        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = '0; dat_i = '0; sel_i = '0;
        cti_i = CTI_CLASSIC; bte_i = BTE_LINEAR;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom;
            model[i] = v;
            dut.ram0.mem[i] = v;
        end
        model[4] = 32'hDEADBEEF; dut.ram0.mem[4] = 32'hDEADBEEF;
        model[1] = 32'h11223344; dut.ram0.mem[1] = 32'h11223344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", {31'd0, ack_o}, 32'd0);
        chk("reset_err", {31'd0, err_o}, 32'd0);
        chk("reset_dat", dat_o, 32'd0);
        chk("rty_zero", {31'd0, rty_o}, 32'd0);
        rst = 1'b0;

        classic(32'h10, 1'b0, 4'hf, 32'd0);
        classic(32'h4, 1'b1, 4'b0010, 32'hAABBCCDD);
        chk("byte_write", dut.ram0.mem[1], 32'h1122CC44);
        burst(32'h18, 1'b0, BTE_WRAP4, 4, -1, 0);
        burst(32'h100, 1'b1, BTE_LINEAR, 3, 0, 2);
        burst(32'h100, 1'b0, BTE_LINEAR, 3, -1, 0);
        classic(MSZ, 1'b0, 4'hf, 32'd0);
        classic(MSZ, 1'b1, 4'hf, 32'h5A5A5A5A);
        chk("oor_no_alias", dut.ram0.mem[0], model[0]);
        burst(MSZ - 8, 1'b0, BTE_LINEAR, 4, 1, 1);
        burst(MSZ - 8, 1'b1, BTE_LINEAR, 4, -1, 0);

        // Reset lands on the second beat of an 8-beat write burst.
        @(posedge clk);
        #1;
        d0 = $urandom;
        expect_beat(32'h200 >> 2, 1'b1, 4'hf, d0);
        cyc_i = 1'b1; we_i = 1'b1; bte_i = BTE_LINEAR; sel_i = 4'hf;
        adr_i = 32'h200; dat_i = d0; cti_i = CTI_INC; stb_i = 1'b1;
        wait_resp("rst_burst", ok);
        @(posedge clk);
        #1;
        adr_i = 32'h204; dat_i = ~model[129]; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack_low", {30'd0, ack_o, err_o}, 32'd0);
        rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        cti_i = CTI_CLASSIC;
        chk("rst_beat0_written", dut.ram0.mem[128], d0);
        chk("rst_beat1_dropped", dut.ram0.mem[129], model[129]);
        classic(32'h204, 1'b0, 4'hf, 32'd0);

        for (int t = 0; t < 40; t++) begin
            int          nb;
            logic [31:0] a;
            a = ($urandom_range(0, WORDS + 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 4) begin
                classic(a, 1'($urandom), 4'($urandom), $urandom);
            end else begin
                nb = $urandom_range(2, 8);
                burst(a, 1'($urandom), 2'($urandom), nb,
                      $urandom_range(0, nb), $urandom_range(0, 3));
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        bad = 0;
        first = -1;
        for (int i = 0; i < WORDS; i++) begin
            if (dut.ram0.mem[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk("mem_image_diffs", bad, 32'd0);
        if (bad != 0) $display("first differing word index %0d", first);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/or1k_wb_ram.md
# or1k_wb_ram

Wishbone B3 memory slave that serves as the main instruction/data RAM of `or1k_pu`, directly downstream of the CPU's Wishbone bus. It provides single-word classic cycles and registered-feedback incrementing bursts (linear and wrap-4/8/16). Its storage array is exposed through a fixed hierarchical path so the simulation top can preload it from an ELF image and clear it before reset release.

## Interface
- `MEM_SIZE`, 32'h02000000: memory size in bytes; must be a multiple of 4.
- `AW`, 32: address width.
- `wb_clk_i`  in  1  system clock; every flop is clocked on the rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wb_adr_i`  in  AW  byte address; bits [1:0] are ignored.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte-lane enables; bit 3 selects `[31:24]`.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle active.
- `wb_stb_i`  in  1  strobe.
- `wb_cti_i`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- `wb_bte_i`  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- `wb_dat_o`  out  32  read data.
- `wb_ack_o`  out  1  transfer acknowledge.
- `wb_err_o`  out  1  out-of-range acknowledge.
- `wb_rty_o`  out  1  tied to 0.

## Operation
- The bus is valid on a cycle when `req = wb_cyc_i & wb_stb_i`.
- **States**
  - IDLE: entered on reset.
  - IDLE -> SINGLE on `req` when `cti != 010`.
  - IDLE -> BURST on `req` when `cti == 010`.
  - SINGLE -> IDLE after one acknowledge cycle.
  - BURST -> IDLE on an acknowledged beat with `cti == 111`, or when `wb_cyc_i` drops.
  - BURST with `stb` low: wait state. No ack is issued and the address holds.
- **Address register `adr_q`** (word address)
  - Loaded from `wb_adr_i[AW-1:2]` on entry from IDLE.
  - Advanced to `next_adr` on every acknowledged burst beat.
  - `next_adr`: linear is `adr_q+1`. For wrap-N, the low log2(N) bits increment modulo N and the upper bits are unchanged.
- **Reads:** `wb_dat_o` is registered as `mem[adr]`.
  - On the first beat, `adr` is the incoming address.
  - On following burst beats, `adr` is `next_adr`.
  - This gives fresh data on every consecutive ack cycle.
- **Writes:** on every cycle with `wb_ack_o & wb_we_i`, the enabled byte lanes of `wb_dat_i` are written to `mem[adr_q]`.
  - Data is sampled in the ack cycle, per Wishbone B3.
  - A write on the same edge as reset is suppressed.
- **Out of range** (byte address >= `MEM_SIZE`)
  - `wb_err_o` is asserted in place of `wb_ack_o`, with the same timing.
  - No write occurs and `wb_dat_o` = 0.
  - A burst that crosses the top of memory errors from the first out-of-range beat onward.
- `wb_rty_o` is always 0.

## Timing
- **Reset values:** `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, state IDLE. Memory contents are not cleared.
- **Classic cycle**
  - `req` first seen at edge n gives ack high in cycle n+1.
  - Ack is forced low in n+2 even if `stb` stays high.
  - Back-to-back classic throughput is one word per 2 cycles.
- **Burst**
  - First ack at n+1, then one ack per cycle while `req` holds.
  - The beat acknowledged with `cti==111` is the last; ack is low the following cycle.
- **`cyc` drop mid-burst:** ack/err is low next cycle and the state returns to IDLE with no further writes.
- **Reset mid-operation:** ack/err is low on the next cycle and the state is IDLE.
- A burst whose first beat has `cti=010` but a later beat changes to `000` is treated as an end-of-burst.

## Structure
- Package `or1k_wb_pkg`: CTI constants (`CTI_CLASSIC`, `CTI_INC`, `CTI_EOB`), BTE constants, `wrap_next()` function.
- Sub-module `or1k_wb_ram_generic`, instance name `ram0`.
  - Synchronous read, per-byte write enable.
  - Array `reg [31:0] mem [0:MEM_SIZE/4-1]`.
  - The path `dut.wb_bfm_memory0.ram0.mem[i]` must remain valid for backdoor ELF load and clear.
- The top holds the FSM, address counter and range check.

## Test plan
- **Classic read:** backdoor load `mem[4]=32'hDEADBEEF`, then read `adr=0x10`, `cti=000` -> ack one cycle later with `dat_o=DEADBEEF`; ack low the next cycle.
- **Byte write:** `mem[1]=0x11223344`; write `adr=0x4`, `sel=0010`, `dat=0xAABBCCDD` -> `mem[1]=0x1122CC44`.
- **Wrap4 burst read:** `adr=0x18`, `bte=01`, four beats with the last `cti=111` -> data `mem[6], mem[7], mem[4], mem[5]` on 4 consecutive ack cycles, then ack=0.
- **Linear burst with wait state:**
  - Write burst at `0x100`, 3 beats, with `stb` low for 2 cycles after beat 1.
  - Required: no ack during the gap, 3 sequential words written, address held across the gap.
- **Out of range:** read at `MEM_SIZE` -> `err=1` for one cycle, `ack=0`, `dat_o=0`. A write to the same address leaves memory unchanged.
- **Reset mid-burst:** assert `wb_rst_i` during beat 2 of an 8-beat write burst -> ack=0 next cycle, beat 2 not written, a new classic read afterwards completes normally.
